// File: rtl/capture_buf_pkg.sv
// Shared types and sizing helpers for the capture page buffer.
package capture_buf_pkg;

  localparam int DEFAULT_PACKET_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH   = 10;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    HOLD,
    READOUT
  } buf_state_e;

  function automatic int page_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra bit so a completely full page is representable.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/capture_page_ram.sv
// Simple dual-port page RAM: one write port, one registered read port.
module capture_page_ram
  import capture_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_PACKET_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = page_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset so the tools can map them onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_page_buffer.sv
// Circular capture page with pre-trigger overwrite and oldest-first readout.
// Optional macro CAPTURE_DROP_COUNT_EN adds a saturating dropped_count output.
module capture_page_buffer
  import capture_buf_pkg::*;
#(
  parameter int PACKET_WIDTH = DEFAULT_PACKET_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PACKET_WIDTH-1:0] samplePacket,
  input  logic                    write_enable,
  input  logic                    preTrigger,
  input  logic                    postTrigger,
  input  logic                    idle,
  input  logic                    arm,
  input  logic                    readout_start,
  output logic                    pageFull,
  output logic [ADDR_WIDTH:0]     stored_count,
  output logic [PACKET_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    rd_last,
  output logic                    busy
`ifdef CAPTURE_DROP_COUNT_EN
  ,
  output logic [31:0]             dropped_count
`endif
);

  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(page_depth(ADDR_WIDTH));

  buf_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, oldest_ptr_q, oldest_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, issue_left_q, issue_left_d;
  logic ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
  logic [PACKET_WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic head_vld_q, head_vld_d, head_last_q, head_last_d;
  logic tail_vld_q, tail_vld_d, tail_last_q, tail_last_d;
  logic page_full_q, page_full_d, busy_q, busy_d;
`ifdef CAPTURE_DROP_COUNT_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;
`endif

  logic                    ram_we, ram_re, pop;
  logic [ADDR_WIDTH-1:0]   ram_waddr, ram_raddr;
  logic [PACKET_WIDTH-1:0] ram_wdata, ram_rdata;
  logic [1:0]              fill_after;

  capture_page_ram #(
    .DATA_WIDTH(PACKET_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  assign pop = head_vld_q && rd_ready;

  // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    oldest_ptr_d = oldest_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    issue_left_d = issue_left_q;
    ram_vld_d    = 1'b0;
    ram_last_d   = ram_last_q;
    head_data_d  = head_data_q;
    head_vld_d   = head_vld_q;
    head_last_d  = head_last_q;
    tail_data_d  = tail_data_q;
    tail_vld_d   = tail_vld_q;
    tail_last_d  = tail_last_q;
`ifdef CAPTURE_DROP_COUNT_EN
    drop_cnt_d   = drop_cnt_q;
`endif
    ram_we       = 1'b0;
    ram_waddr    = wr_ptr_q;
    ram_wdata    = samplePacket;
    ram_re       = 1'b0;
    ram_raddr    = rd_ptr_q;
    fill_after   = 2'(head_vld_q) + 2'(tail_vld_q) + 2'(ram_vld_q) - 2'(pop);

    if (arm) begin
      state_d      = FILL;
      wr_ptr_d     = '0;
      oldest_ptr_d = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      issue_left_d = '0;
      head_vld_d   = 1'b0;
      head_last_d  = 1'b0;
      tail_vld_d   = 1'b0;
      tail_last_d  = 1'b0;
`ifdef CAPTURE_DROP_COUNT_EN
      drop_cnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        EMPTY: ;
        FILL: begin
          if (write_enable && preTrigger) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q < DEPTH_C) count_d = count_q + 1'b1;
            else                   oldest_ptr_d = oldest_ptr_q + 1'b1;
          end else if (write_enable && postTrigger) begin
            if (count_q < DEPTH_C) begin
              ram_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              count_d  = count_q + 1'b1;
            end
`ifdef CAPTURE_DROP_COUNT_EN
            else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
`endif
          end
          if (idle) state_d = HOLD;
        end
        HOLD: begin
          if (readout_start) begin
            if (count_q != '0) begin
              // First read issues on the start edge so data leaves two cycles later.
              state_d      = READOUT;
              ram_re       = 1'b1;
              ram_raddr    = oldest_ptr_q;
              rd_ptr_d     = oldest_ptr_q + 1'b1;
              issue_left_d = count_q - 1'b1;
              ram_vld_d    = 1'b1;
              ram_last_d   = (count_q == CW'(1));
            end else begin
              state_d = EMPTY;
            end
          end
        end
        READOUT: begin
          // Issue only if the skid pair still has room for this read even when stalled.
          if (issue_left_q != '0 && fill_after <= 2'd1) begin
            ram_re       = 1'b1;
            rd_ptr_d     = rd_ptr_q + 1'b1;
            issue_left_d = issue_left_q - 1'b1;
            ram_vld_d    = 1'b1;
            ram_last_d   = (issue_left_q == CW'(1));
          end
          if (pop) begin
            head_data_d = tail_data_q;
            head_last_d = tail_vld_q && tail_last_q;
            head_vld_d  = tail_vld_q;
            tail_vld_d  = 1'b0;
            count_d     = count_q - 1'b1;
          end
          if (ram_vld_q) begin
            if (!head_vld_d) begin
              head_data_d = ram_rdata;
              head_last_d = ram_last_q;
              head_vld_d  = 1'b1;
            end else begin
              tail_data_d = ram_rdata;
              tail_last_d = ram_last_q;
              tail_vld_d  = 1'b1;
            end
          end
          if (pop && head_last_q) state_d = EMPTY;
        end
      endcase
    end

    page_full_d = (state_d == FILL) && postTrigger && (count_d == DEPTH_C);
    busy_d      = (state_d != EMPTY);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      wr_ptr_q     <= '0;
      oldest_ptr_q <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      issue_left_q <= '0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      head_data_q  <= '0;
      head_vld_q   <= 1'b0;
      head_last_q  <= 1'b0;
      tail_data_q  <= '0;
      tail_vld_q   <= 1'b0;
      tail_last_q  <= 1'b0;
      page_full_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef CAPTURE_DROP_COUNT_EN
      drop_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      oldest_ptr_q <= oldest_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      issue_left_q <= issue_left_d;
      ram_vld_q    <= ram_vld_d;
      ram_last_q   <= ram_last_d;
      head_data_q  <= head_data_d;
      head_vld_q   <= head_vld_d;
      head_last_q  <= head_last_d;
      tail_data_q  <= tail_data_d;
      tail_vld_q   <= tail_vld_d;
      tail_last_q  <= tail_last_d;
      page_full_q  <= page_full_d;
      busy_q       <= busy_d;
`ifdef CAPTURE_DROP_COUNT_EN
      drop_cnt_q   <= drop_cnt_d;
`endif
    end
  end

  assign pageFull     = page_full_q;
  assign stored_count = count_q;
  assign rd_data      = head_data_q;
  assign rd_valid     = head_vld_q;
  assign rd_last      = head_last_q;
  assign busy         = busy_q;
`ifdef CAPTURE_DROP_COUNT_EN
  assign dropped_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_capture_page_buffer.sv
// Bench for capture_page_buffer: vector table, directed corner cases, and random runs against a queue model.
module tb_capture_page_buffer;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int PW    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [PW-1:0] samplePacket;
  logic          write_enable, preTrigger, postTrigger, idle, arm, readout_start, rd_ready;
  logic          pageFull, rd_valid, rd_last, busy;
  logic [AW:0]   stored_count;
  logic [PW-1:0] rd_data;
`ifdef CAPTURE_DROP_COUNT_EN
  logic [31:0]   dropped_count;
`endif

  capture_page_buffer #(.PACKET_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .samplePacket (samplePacket),
    .write_enable (write_enable),
    .preTrigger   (preTrigger),
    .postTrigger  (postTrigger),
    .idle         (idle),
    .arm          (arm),
    .readout_start(readout_start),
    .pageFull     (pageFull),
    .stored_count (stored_count),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_last      (rd_last),
    .busy         (busy)
`ifdef CAPTURE_DROP_COUNT_EN
    ,
    .dropped_count(dropped_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef enum {M_EMPTY, M_FILL, M_HOLD, M_READ} mmode_e;
  mmode_e        m_mode = M_EMPTY;
  logic [PW-1:0] m_q[$];
  logic [31:0]   m_drops = '0;
  logic [PW-1:0] got[$];
  int            last_seen;

  typedef struct {
    bit          arm, we, pre, post, idl;
    logic [31:0] pkt;
    int          exp_count;
    bit          exp_full, exp_busy;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode  = M_EMPTY;
    m_drops = '0;
  endtask

  // One clock: check the handshake about to happen, advance the model, then compare outputs.
  task automatic tick();
    logic acc, stall, arm_s, we_s, pre_s, post_s, idle_s, rs_s, held_last;
    logic [PW-1:0] pkt_s, held;
    acc = rd_valid && rd_ready;
    stall = rd_valid && !rd_ready;
    held = rd_data; held_last = rd_last;
    arm_s = arm; we_s = write_enable; pre_s = preTrigger; post_s = postTrigger;
    idle_s = idle; rs_s = readout_start; pkt_s = samplePacket;
    if (acc) begin
      if (m_mode != M_READ || m_q.size() == 0) check("rd_valid_outside_readout", rd_valid, 0);
      else begin
        check("rd_data", rd_data, m_q[0]);
        check("rd_last", rd_last, m_q.size() == 1);
      end
      got.push_back(rd_data);
      if (rd_last) last_seen++;
    end
    @(posedge clk);
    if (arm_s) begin
      m_q.delete(); m_mode = M_FILL; m_drops = '0;
    end else begin
      case (m_mode)
        M_FILL: begin
          if (we_s && pre_s) begin
            m_q.push_back(pkt_s);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
          end else if (we_s && post_s) begin
            if (m_q.size() < DEPTH) m_q.push_back(pkt_s);
            else if (m_drops != 32'hFFFF_FFFF) m_drops++;
          end
          if (idle_s) m_mode = M_HOLD;
        end
        M_HOLD: if (rs_s) m_mode = (m_q.size() > 0) ? M_READ : M_EMPTY;
        M_READ: if (acc && m_q.size() > 0) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_mode = M_EMPTY;
        end
        default: ;
      endcase
    end
    #1;
    check("stored_count", stored_count, m_q.size());
    check("pageFull", pageFull, (m_mode == M_FILL) && post_s && (m_q.size() == DEPTH));
    check("busy", busy, m_mode != M_EMPTY);
    if (m_mode != M_READ) check("rd_valid_not_reading", rd_valid, 0);
    else if (stall && !arm_s) begin
      check("stall_valid", rd_valid, 1);
      check("stall_data", rd_data, held);
      check("stall_last", rd_last, held_last);
    end
`ifdef CAPTURE_DROP_COUNT_EN
    check("dropped_count", dropped_count, m_drops);
`endif
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic write_pkt(input bit pre, input bit post, input logic [PW-1:0] d);
    preTrigger = pre; postTrigger = post; samplePacket = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic end_capture();
    preTrigger = 1'b0; postTrigger = 1'b0; idle = 1'b1;
    tick();
    idle = 1'b0;
  endtask

  // pat: 0 always ready, 1 ready 1,0,0 repeating, 2 random ready
  task automatic run_readout(input int pat, input bit chk_latency);
    int n = 0;
    got.delete(); last_seen = 0;
    readout_start = 1'b1; rd_ready = 1'b1;
    tick();
    readout_start = 1'b0;
    if (chk_latency) check("first_valid_early", rd_valid, 0);
    while (m_mode == M_READ && n < 300) begin
      case (pat)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (n % 3 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      if (chk_latency && n == 0) check("first_valid", rd_valid, 1);
      n++;
    end
    check("readout_timeout", m_mode == M_READ, 0);
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] exp_bp[5];

    vecs[0]  = '{1, 0, 0, 0, 0, 32'd0,   0, 0, 1};
    vecs[1]  = '{0, 1, 1, 0, 0, 32'd100, 1, 0, 1};
    vecs[2]  = '{0, 1, 1, 0, 0, 32'd101, 2, 0, 1};
    vecs[3]  = '{0, 1, 1, 0, 0, 32'd102, 3, 0, 1};
    vecs[4]  = '{0, 1, 0, 1, 0, 32'd103, 4, 0, 1};
    vecs[5]  = '{0, 1, 0, 1, 0, 32'd104, 5, 0, 1};
    vecs[6]  = '{0, 1, 0, 1, 0, 32'd105, 6, 0, 1};
    vecs[7]  = '{0, 1, 0, 1, 0, 32'd106, 7, 0, 1};
    vecs[8]  = '{0, 1, 0, 1, 0, 32'd107, 8, 1, 1};
    vecs[9]  = '{0, 1, 0, 1, 0, 32'd108, 8, 1, 1};
    vecs[10] = '{0, 1, 0, 1, 0, 32'd109, 8, 1, 1};
    vecs[11] = '{0, 0, 0, 1, 0, 32'd0,   8, 1, 1};
    vecs[12] = '{0, 0, 0, 0, 1, 32'd0,   8, 0, 1};

    reset = 1'b1; samplePacket = '0; write_enable = 1'b0; preTrigger = 1'b0;
    postTrigger = 1'b0; idle = 1'b0; arm = 1'b0; readout_start = 1'b0; rd_ready = 1'b0;

    // Reset state
    #12;
    check("rst_count", stored_count, 0);
    check("rst_pageFull", pageFull, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    model_reset();

    // Post-trigger full, driven from the vector table
    for (int i = 0; i < 13; i++) begin
      arm = vecs[i].arm; write_enable = vecs[i].we; preTrigger = vecs[i].pre;
      postTrigger = vecs[i].post; idle = vecs[i].idl; samplePacket = vecs[i].pkt;
      tick();
      check($sformatf("tbl%0d_count", i), stored_count, vecs[i].exp_count);
      check($sformatf("tbl%0d_full", i), pageFull, vecs[i].exp_full);
      check($sformatf("tbl%0d_busy", i), busy, vecs[i].exp_busy);
    end
    arm = 1'b0; write_enable = 1'b0; postTrigger = 1'b0; idle = 1'b0;
`ifdef CAPTURE_DROP_COUNT_EN
    check("tbl_dropped", dropped_count, 2);
`endif
    run_readout(0, 1'b1);
    check("tbl_read_len", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check($sformatf("tbl_pkt%0d", i), got[i], 100 + i);

    // Pre-trigger wrap
    do_arm();
    for (int i = 0; i < 12; i++) write_pkt(1'b1, 1'b0, PW'(i));
    end_capture();
    run_readout(0, 1'b0);
    check("wrap_len", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check($sformatf("wrap_pkt%0d", i), got[i], 4 + i);
    check("wrap_last_once", last_seen, 1);
    check("wrap_count_end", stored_count, 0);

    // Backpressure
    do_arm();
    for (int i = 0; i < 5; i++) begin
      exp_bp[i] = $urandom;
      write_pkt(1'b1, 1'b0, exp_bp[i]);
    end
    end_capture();
    run_readout(1, 1'b0);
    check("bp_len", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check($sformatf("bp_pkt%0d", i), got[i], exp_bp[i]);
    check("bp_last_once", last_seen, 1);

    // Abort via arm after two accepts
    do_arm();
    for (int i = 0; i < 6; i++) write_pkt(1'b1, 1'b0, PW'(32'h50 + i));
    end_capture();
    got.delete(); last_seen = 0;
    readout_start = 1'b1; tick(); readout_start = 1'b0;
    rd_ready = 1'b1;
    for (int n = 0; n < 20 && got.size() < 2; n++) tick();
    check("abort_two_accepts", got.size(), 2);
    rd_ready = 1'b0;
    do_arm();
    check("abort_rd_valid", rd_valid, 0);
    check("abort_count", stored_count, 0);
    check("abort_busy", busy, 1);
    write_pkt(1'b1, 1'b0, 32'hABCD);
    check("abort_fill_write", stored_count, 1);
    end_capture();
    run_readout(0, 1'b0);
    check("abort_drain_len", got.size(), 1);

    // Asynchronous reset while full in post-trigger
    do_arm();
    for (int i = 0; i < 8; i++) write_pkt(1'b0, 1'b1, PW'(i));
    tick();
    check("pf_before_reset", pageFull, 1);
    #3 reset = 1'b1;
    #1;
    check("areset_pageFull", pageFull, 0);
    check("areset_busy", busy, 0);
    check("areset_count", stored_count, 0);
    postTrigger = 1'b0;
    #2 reset = 1'b0;
    model_reset();

    // Empty readout
    do_arm();
    end_capture();
    run_readout(0, 1'b0);
    tick();
    tick();
    check("empty_busy", busy, 0);
    check("empty_len", got.size(), 0);

    // Randomized captures against the queue model
    for (int r = 0; r < 20; r++) begin
      int npre, npost;
      npre  = $urandom_range(0, 14);
      npost = $urandom_range(0, 11);
      do_arm();
      for (int i = 0; i < npre; i++) begin
        if ($urandom_range(0, 3) == 0) write_pkt(1'b0, 1'b0, $urandom);
        write_pkt(1'b1, 1'b0, $urandom);
      end
      for (int i = 0; i < npost; i++) write_pkt(1'b0, 1'b1, $urandom);
      end_capture();
      run_readout(2, 1'b0);
      check("rnd_last_once", last_seen, (got.size() > 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_page_buffer.md
Name: capture_page_buffer

Overview:
- Sits directly downstream of the logic-capture core. Consumes its packet stream (samplePacket/write_enable) and its phase flags (preTrigger/postTrigger/idle), and returns pageFull to it.
- Stores packets in a circular on-chip RAM page. During pre-trigger, the oldest data is overwritten. During post-trigger, data is never overwritten.
- After capture ends, streams the page oldest-first to the host uplink over a valid/ready handshake.

Parameters:
- PACKET_WIDTH, 32, width of one stored packet (matches the core's SAMPLE_PACKET_WIDTH).
- ADDR_WIDTH, 10, RAM address width; DEPTH = 2**ADDR_WIDTH entries.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high; clears all state.
- samplePacket  in  PACKET_WIDTH  packet from capture core.
- write_enable  in  1  packet qualifier, one packet per cycle.
- preTrigger  in  1  core is in pre-trigger phase.
- postTrigger  in  1  core is in post-trigger phase.
- idle  in  1  core is idle.
- arm  in  1  one-cycle pulse; empties page and enters FILL (pulse together with core start).
- readout_start  in  1  one-cycle pulse; starts readout (honoured only in HOLD).
- pageFull  out  1  page full during post-trigger; to core.
- stored_count  out  ADDR_WIDTH+1  valid entries in page.
- rd_data  out  PACKET_WIDTH  readout packet.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  sink accepts rd_data.
- rd_last  out  1  marks final packet of the page.
- busy  out  1  state != EMPTY.

Behaviour:
- Reset values: state EMPTY; wr_ptr, oldest_ptr, stored_count, rd_valid, rd_last, pageFull, busy = 0; rd_data = 0.
- States: EMPTY, FILL, HOLD, READOUT.
- EMPTY -> FILL on arm.
- FILL -> HOLD on the first cycle idle=1 after arm was seen.
- HOLD -> READOUT on readout_start when stored_count > 0. With stored_count = 0, readout_start returns to EMPTY.
- READOUT -> EMPTY after the handshake with rd_last=1.
- arm in any state clears the pointers and count and enters FILL; an in-flight readout is abandoned and rd_valid drops next cycle.
- FILL, preTrigger=1, write_enable=1:
  - write at wr_ptr; wr_ptr++ (wraps modulo DEPTH).
  - If stored_count < DEPTH, stored_count++. Otherwise oldest_ptr++ (overwrite oldest).
- FILL, postTrigger=1, write_enable=1:
  - If stored_count < DEPTH: write, wr_ptr++, stored_count++.
  - If stored_count == DEPTH: the packet is dropped; nothing changes.
- write_enable while neither phase flag is high, or outside FILL: ignored.
- pageFull is registered: pageFull = (state == FILL) && postTrigger && (stored_count == DEPTH).
  - Rises the cycle after the write that fills the page.
  - If the page is already full at the moment of trigger, it rises on the first post-trigger cycle.
  - Clears on arm, reset, or leaving FILL.
- READOUT:
  - Read address starts at oldest_ptr and wraps modulo DEPTH; exactly stored_count packets are emitted.
  - RAM read latency is 1 cycle. A 2-entry output skid register keeps rd_valid continuous while rd_ready=1: one packet per cycle, first rd_valid 2 cycles after readout_start.
  - rd_data and rd_last are held stable while rd_valid=1 and rd_ready=0.
  - stored_count decrements per accepted packet.
  - rd_last=1 on the packet whose acceptance drives stored_count to 0.
- Simultaneous events:
  - write_enable and arm in the same cycle: arm wins and the packet is discarded.
  - Reset mid-readout: outputs go low immediately (asynchronous); RAM contents are irrelevant.
- Widths: pointers are ADDR_WIDTH bits with natural wrap. stored_count is ADDR_WIDTH+1 bits so it can represent DEPTH.

Optional Feature:
- Macro: CAPTURE_DROP_COUNT_EN.
- Defined:
  - Adds output dropped_count (32 bits), counting packets rejected in FILL/postTrigger while full.
  - Saturates at 0xFFFFFFFF; clears on arm or reset.
- Undefined: the port and the counter are absent; drop behaviour is unchanged.

Decomposition:
- Package capture_buf_pkg holds:
  - the state enum (EMPTY, FILL, HOLD, READOUT);
  - localparam helpers for DEPTH and count width.
- Sub-module capture_page_ram: simple dual-port RAM with one write port, one registered read port, no reset on the array (infers BRAM).
- FSM, pointers, and the skid register stay in capture_page_buffer.

Test Plan:
- Pre-trigger wrap, ADDR_WIDTH=3:
  - Stimulus: arm; 12 pre-trigger packets 0..11; idle; readout_start with rd_ready=1.
  - Required: 8 packets 4..11 in order, rd_last on packet 11, stored_count ends at 0.
- Post-trigger full, ADDR_WIDTH=3:
  - Stimulus: arm; 3 pre-trigger packets; 7 post-trigger packets.
  - Required: pageFull rises the cycle after the 5th post-trigger write; last 2 packets dropped; readout yields 8 packets; dropped_count=2 with macro.
- Backpressure:
  - Stimulus: readout of 5 packets with rd_ready toggling 1,0,0,1,...
  - Required: no duplicate or lost packet; rd_data stable while stalled; rd_last exactly once.
- Abort via arm:
  - Stimulus: arm pulsed mid-readout after 2 accepts.
  - Required: rd_valid=0 the next cycle; stored_count=0; state FILL.
- Async reset:
  - Stimulus: reset asserted between clock edges in FILL with pageFull=1.
  - Required: pageFull, busy, and stored_count = 0 before the next clk edge.
- Empty readout:
  - Stimulus: arm then idle with no packets; readout_start.
  - Required: no rd_valid; state returns to EMPTY.
